mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving a CPU and a DMA requester shared access to one
// single-port data memory; reads take a grant cycle plus a data-return cycle.
module mem_port_arbiter #(
    parameter int unsigned ADDR_LIMIT = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_adr,
    input  logic [31:0] i_cpu_wdata,
    output logic        o_cpu_gnt,
    output logic        o_cpu_rvalid,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_err,
    input  logic        i_dma_req,
    input  logic        i_dma_we,
    input  logic [31:0] i_dma_adr,
    input  logic [31:0] i_dma_wdata,
    output logic        o_dma_gnt,
    output logic        o_dma_rvalid,
    output logic [31:0] o_dma_rdata,
    output logic        o_dma_err,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_en_read,
    output logic        o_mem_en_write,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_READ_WAIT = 1'b1
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_owner;
    logic        r_read_owner;
    logic        r_read_err;

    logic        w_grant;
    logic        w_winner;
    logic        w_sel_we;
    logic [31:0] w_sel_adr;
    logic [31:0] w_sel_wdata;
    logic        w_in_range;

    // Winner selection: a tie goes to whoever did not win last time.
    always_comb begin
        w_winner = OWNER_CPU;
        if (i_cpu_req && i_dma_req) begin
            w_winner = (r_last_owner == OWNER_DMA) ? OWNER_CPU : OWNER_DMA;
        end else if (i_dma_req) begin
            w_winner = OWNER_DMA;
        end else begin
            w_winner = OWNER_CPU;
        end
        w_sel_we    = (w_winner == OWNER_DMA) ? i_dma_we    : i_cpu_we;
        w_sel_adr   = (w_winner == OWNER_DMA) ? i_dma_adr   : i_cpu_adr;
        w_sel_wdata = (w_winner == OWNER_DMA) ? i_dma_wdata : i_cpu_wdata;
        w_in_range  = (w_sel_adr < 32'(ADDR_LIMIT));
    end

    // Next-state and output decode; everything is forced quiet while rst is low.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant        = 1'b0;
        o_cpu_gnt      = 1'b0;
        o_dma_gnt      = 1'b0;
        o_cpu_err      = 1'b0;
        o_dma_err      = 1'b0;
        o_cpu_rvalid   = 1'b0;
        o_dma_rvalid   = 1'b0;
        o_cpu_rdata    = 32'h0000_0000;
        o_dma_rdata    = 32'h0000_0000;
        o_mem_adr      = 32'h0000_0000;
        o_mem_wdata    = 32'h0000_0000;
        o_mem_en_read  = 1'b0;
        o_mem_en_write = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rst && (i_cpu_req || i_dma_req)) begin
                    w_grant        = 1'b1;
                    o_cpu_gnt      = (w_winner == OWNER_CPU);
                    o_dma_gnt      = (w_winner == OWNER_DMA);
                    o_cpu_err      = (w_winner == OWNER_CPU) && !w_in_range;
                    o_dma_err      = (w_winner == OWNER_DMA) && !w_in_range;
                    o_mem_adr      = w_sel_adr;
                    o_mem_wdata    = w_sel_wdata;
                    o_mem_en_write = w_sel_we && w_in_range;
                    o_mem_en_read  = !w_sel_we && w_in_range;
                    // Out-of-range reads still take the return cycle so rvalid is always delivered.
                    w_state_nxt    = w_sel_we ? ST_IDLE : ST_READ_WAIT;
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_READ_WAIT: begin
                if (rst) begin
                    o_cpu_rvalid = (r_read_owner == OWNER_CPU);
                    o_dma_rvalid = (r_read_owner == OWNER_DMA);
                    o_cpu_rdata  = (r_read_owner == OWNER_CPU && !r_read_err) ? i_mem_rdata : 32'h0000_0000;
                    o_dma_rdata  = (r_read_owner == OWNER_DMA && !r_read_err) ? i_mem_rdata : 32'h0000_0000;
                end else begin
                    o_cpu_rvalid = 1'b0;
                    o_dma_rvalid = 1'b0;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, round-robin history and pending-read bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_owner <= OWNER_DMA;
            r_read_owner <= OWNER_CPU;
            r_read_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_last_owner <= w_winner;
                r_read_owner <= w_winner;
                r_read_err   <= !w_in_range;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: scripted and random requester traffic,
// a memory stub, and a transaction-level reference model checked every cycle.
module tb_mem_port_arbiter;
    localparam int unsigned LIMIT = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_adr, cpu_wdata, dma_adr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_err, dma_gnt, dma_rvalid, dma_err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic        mem_en_read, mem_en_write;

    mem_port_arbiter #(.ADDR_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_adr(cpu_adr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata), .o_cpu_err(cpu_err),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_adr(dma_adr), .i_dma_wdata(dma_wdata),
        .o_dma_gnt(dma_gnt), .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata), .o_dma_err(dma_err),
        .o_mem_adr(mem_adr), .o_mem_wdata(mem_wdata), .o_mem_en_read(mem_en_read),
        .o_mem_en_write(mem_en_write), .i_mem_rdata(mem_rdata)
    );

    typedef struct { logic we; logic [31:0] adr; logic [31:0] wdata; int gap; } txn_t;
    typedef struct { logic owner; logic [31:0] data; } rd_t;

    txn_t        cpu_txq[$], dma_txq[$], cpu_exp_q[$], dma_exp_q[$];
    rd_t         rd_q[$];
    logic [31:0] ram     [0:127];
    logic [31:0] ref_mem [0:127];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        busy_m = 1'b0;
    logic        tie_pref_m = 1'b0;
    logic        cpu_gnt_seen = 1'b0, dma_gnt_seen = 1'b0;
    bit          cpu_active = 1'b0, dma_active = 1'b0;
    int          cpu_wait = 0, dma_wait = 0;

    // Registered-output memory stub: read data appears the cycle after the enable.
    always @(posedge clk) begin
        if (mem_en_write) ram[mem_adr[6:0]] <= mem_wdata;
        if (mem_en_read)  mem_rdata <= ram[mem_adr[6:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: reference model of arbitration, memory and read return, checked mid-cycle.
    always @(negedge clk) begin : mon
        logic exp_cg, exp_dg, g, in_r;
        txn_t t;
        rd_t  r;
        if (rst === 1'b0) begin
            chk("rst_quiet", 32'({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dma_err,
                                  mem_en_read, mem_en_write}), 32'd0);
            busy_m     = 1'b0;
            tie_pref_m = 1'b0;
            rd_q.delete();
        end else begin
            if (busy_m) begin
                if (rd_q.size() == 0) begin
                    fail_now("rd_q_empty");
                end else begin
                    r = rd_q.pop_front();
                    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(r.owner == 1'b0));
                    chk("dma_rvalid", 32'(dma_rvalid), 32'(r.owner == 1'b1));
                    chk("cpu_rdata", cpu_rdata, (r.owner == 1'b0) ? r.data : 32'd0);
                    chk("dma_rdata", dma_rdata, (r.owner == 1'b1) ? r.data : 32'd0);
                end
            end else begin
                chk("rvalid_idle", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
                chk("rdata_idle", cpu_rdata | dma_rdata, 32'd0);
            end
            exp_cg = 1'b0;
            exp_dg = 1'b0;
            if (!busy_m) begin
                if (cpu_req && dma_req) begin
                    exp_cg = (tie_pref_m == 1'b0);
                    exp_dg = !exp_cg;
                end else begin
                    exp_cg = cpu_req;
                    exp_dg = dma_req;
                end
            end
            chk("gnt", 32'({cpu_gnt, dma_gnt}), 32'({exp_cg, exp_dg}));
            busy_m = 1'b0;
            if (exp_cg || exp_dg) begin
                g = exp_dg;
                if ((g == 1'b0 && cpu_exp_q.size() == 0) || (g == 1'b1 && dma_exp_q.size() == 0)) begin
                    fail_now("exp_q_empty");
                end else begin
                    t = (g == 1'b0) ? cpu_exp_q.pop_front() : dma_exp_q.pop_front();
                    in_r = (t.adr < LIMIT);
                    chk("mem_en_write", 32'(mem_en_write), 32'(t.we && in_r));
                    chk("mem_en_read", 32'(mem_en_read), 32'(!t.we && in_r));
                    chk("mem_adr", mem_adr, t.adr);
                    chk("mem_wdata", mem_wdata, t.wdata);
                    chk("err", 32'({cpu_err, dma_err}), 32'({!g && !in_r, g && !in_r}));
                    if (t.we && in_r) ref_mem[t.adr[6:0]] = t.wdata;
                    if (!t.we) begin
                        r.owner = g;
                        r.data  = in_r ? ref_mem[t.adr[6:0]] : 32'd0;
                        rd_q.push_back(r);
                        busy_m = 1'b1;
                    end
                    tie_pref_m = !g;
                end
            end else begin
                chk("idle_mem", 32'({mem_en_read, mem_en_write, cpu_err, dma_err}), 32'd0);
                chk("idle_bus", mem_adr | mem_wdata, 32'd0);
            end
        end
        cpu_gnt_seen = cpu_gnt;
        dma_gnt_seen = dma_gnt;
    end

    // One cycle of requester behaviour: retire granted requests, present queued ones.
    task automatic step();
        txn_t t;
        @(posedge clk);
        #1;
        if (cpu_active && cpu_gnt_seen) cpu_active = 1'b0;
        if (dma_active && dma_gnt_seen) dma_active = 1'b0;
        if (!cpu_active && cpu_txq.size() > 0) begin
            if (cpu_wait >= cpu_txq[0].gap) begin
                t = cpu_txq.pop_front();
                cpu_we = t.we; cpu_adr = t.adr; cpu_wdata = t.wdata;
                cpu_exp_q.push_back(t);
                cpu_active = 1'b1;
                cpu_wait = 0;
            end else cpu_wait++;
        end
        if (!dma_active && dma_txq.size() > 0) begin
            if (dma_wait >= dma_txq[0].gap) begin
                t = dma_txq.pop_front();
                dma_we = t.we; dma_adr = t.adr; dma_wdata = t.wdata;
                dma_exp_q.push_back(t);
                dma_active = 1'b1;
                dma_wait = 0;
            end else dma_wait++;
        end
        if (!cpu_active) begin cpu_we = 1'($urandom); cpu_adr = $urandom; cpu_wdata = $urandom; end
        if (!dma_active) begin dma_we = 1'($urandom); dma_adr = $urandom; dma_wdata = $urandom; end
        cpu_req = cpu_active;
        dma_req = dma_active;
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] adr, input logic [31:0] wdata, input int gap);
        txn_t t;
        t.we = we; t.adr = adr; t.wdata = wdata; t.gap = gap;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        logic [31:0] a;
        case ($urandom_range(0, 11))
            0: a = 32'd127;
            1: a = 32'd128;
            2: a = 32'd200;
            3: a = 32'hFFFF_FFFF;
            4: a = 32'h8000_0005;
            default: a = 32'($urandom_range(0, 127));
        endcase
        return mk(1'($urandom), a, $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    endfunction

    task automatic drain();
        int k = 0;
        while ((cpu_txq.size() > 0 || dma_txq.size() > 0 || cpu_active || dma_active || busy_m) && k < 2000) begin
            step();
            k++;
        end
        if (k >= 2000) fail_now("drain_timeout");
        step();
        step();
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 128; i++) begin
            ram[i]     = 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101);
            ref_mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101);
        end
        mem_rdata = 32'hDEAD_BEEF;
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = 32'd0; cpu_wdata = 32'd0;
        dma_req = 1'b0; dma_we = 1'b0; dma_adr = 32'd0; dma_wdata = 32'd0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // Single CPU write then read of the same word.
        cpu_txq.push_back(mk(1'b1, 32'd5, 32'hA5A5_A5A5, 0));
        drain();
        cpu_txq.push_back(mk(1'b0, 32'd5, 32'd0, 0));
        drain();

        // Continuous contention after reset: grants alternate starting with CPU.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            cpu_txq.push_back(mk(1'b1, 32'(10 + i), $urandom, 0));
            dma_txq.push_back(mk(1'b1, 32'(20 + i), $urandom, 0));
        end
        drain();

        // Out-of-range DMA read, then simultaneous reads.
        dma_txq.push_back(mk(1'b0, 32'd200, 32'd0, 0));
        drain();
        cpu_txq.push_back(mk(1'b0, 32'd10, 32'd0, 0));
        dma_txq.push_back(mk(1'b0, 32'd21, 32'd0, 0));
        drain();

        // Reset while a CPU read is outstanding; the next tie still goes to CPU.
        cpu_txq.push_back(mk(1'b0, 32'd7, 32'd0, 0));
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            got = cpu_gnt_seen;
        end
        if (!got) fail_now("rst_read_gnt_timeout");
        pulse_reset();
        cpu_txq.push_back(mk(1'b1, 32'd30, 32'h1111_2222, 0));
        dma_txq.push_back(mk(1'b1, 32'd31, 32'h3333_4444, 0));
        drain();

        // Random traffic with occasional resets.
        for (int i = 0; i < 250; i++) begin
            cpu_txq.push_back(rnd_txn());
            dma_txq.push_back(rnd_txn());
        end
        for (int k = 0; k < 3000 && (cpu_txq.size() > 0 || dma_txq.size() > 0); k++) begin
            step();
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end
        drain();

        chk("exp_q_left", 32'(cpu_exp_q.size() + dma_exp_q.size()), 32'd0);
        chk("rd_q_left", 32'(rd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
